// File: rtl/dcpu_fetch.sv
// dcpu_fetch: variable-length (1..3 word) instruction fetch unit for the dcpu core.
// Fetches over a 16-bit bus with banked supervisor/user PCs. Each complete
// instruction is handed to execute through a valid/ready handshake.
// Branch redirects from execute take priority over everything except reset.
// Optional feature macro: DCPU_FETCH_IRQ_EN. When it is defined, interrupts
// are entered at instruction boundaries. When it is undefined, i_int is
// ignored and o_irq_taken is tied low.
module dcpu_fetch #(
    parameter int          ADDR_W     = 32,
    parameter int          PC_STEP    = 1,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] IRQ_VECTOR = 32'h10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    // bus master
    output logic              o_cyc,
    output logic [1:0]        o_stb,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    input  logic              i_ack,
    input  logic [15:0]       i_dat,
    // execute side
    input  logic              i_ub,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [15:0]       o_ir,
    output logic [31:0]       o_imm,
    output logic [1:0]        o_len,
    output logic [ADDR_W-1:0] o_pc,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_int,
    output logic              o_irq_taken
);

    localparam logic [ADDR_W-1:0] PC_RST = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] PC_IRQ = IRQ_VECTOR[ADDR_W-1:0];

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_FETCH2 = 3'd2,
        ST_FETCH3 = 3'd3,
        ST_HOLD   = 3'd4
`ifdef DCPU_FETCH_IRQ_EN
        ,ST_IRQ   = 3'd5
`endif
    } state_t;

    state_t            state;
    state_t            state_next;
    state_t            boundary_next;  // target at an instruction boundary
    logic [ADDR_W-1:0] pc_sup;
    logic [ADDR_W-1:0] pc_usr;
    logic [ADDR_W-1:0] active_pc;
    logic              fetching;
    logic              take;           // ack that is actually consumed
    logic              cyc_d;
    logic [1:0]        stb_d;
    logic              valid_d;

    assign o_we      = 1'b0;
    assign active_pc = i_ub ? pc_usr : pc_sup;
    assign fetching  = (state == ST_FETCH1) || (state == ST_FETCH2) || (state == ST_FETCH3);
    // A redirect kills the word arriving in the same cycle.
    assign take      = fetching && i_ack && !i_redirect;

`ifdef DCPU_FETCH_IRQ_EN
    assign boundary_next = (i_int && i_ub) ? ST_IRQ : ST_FETCH1;
`else
    logic [ADDR_W:0] unused_irq;
    assign boundary_next = ST_FETCH1;
    assign unused_irq    = {i_int, PC_IRQ};
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (i_reset) state <= ST_RESET;
        else         state <= state_next;
    end

    // Next-state decode; redirect overrides every transition.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no
        // latch is inferred.
        state_next = state;
        if (i_redirect) begin
            state_next = ST_FETCH1;
        end else begin
            case (state)
                ST_RESET:  state_next = boundary_next;
                ST_FETCH1: if (i_ack) state_next = (i_dat[15:13] == 3'b111) ? ST_FETCH2 : ST_HOLD;
                ST_FETCH2: if (i_ack) state_next = (o_ir[12:11] == 2'b11) ? ST_FETCH3 : ST_HOLD;
                ST_FETCH3: if (i_ack) state_next = ST_HOLD;
                ST_HOLD:   if (o_valid && i_ready) state_next = boundary_next;
`ifdef DCPU_FETCH_IRQ_EN
                ST_IRQ:    state_next = ST_FETCH1;
`endif
                default:   state_next = ST_RESET;
            endcase
        end
    end

    // Output decode: next-cycle bus/handshake values plus the combinational address.
    always_comb begin
        cyc_d   = (state_next == ST_FETCH1) || (state_next == ST_FETCH2) ||
                  (state_next == ST_FETCH3);
        stb_d   = cyc_d ? 2'b11 : 2'b00;
        valid_d = (state_next == ST_HOLD);
        o_addr  = fetching ? active_pc : '0;
    end

    // Registered bus and handshake outputs, aligned with the state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cyc   <= 1'b0;
            o_stb   <= 2'b00;
            o_valid <= 1'b0;
        end else begin
            o_cyc   <= cyc_d;
            o_stb   <= stb_d;
            o_valid <= valid_d;
        end
    end

`ifdef DCPU_FETCH_IRQ_EN
    // One-cycle pulse marking the cycle spent in IRQ.
    always_ff @(posedge i_clk) begin
        if (i_reset) o_irq_taken <= 1'b0;
        else         o_irq_taken <= (state_next == ST_IRQ);
    end
`else
    assign o_irq_taken = 1'b0;
`endif

    // Instruction capture; only consumed acks write, so fields hold steady in HOLD.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ir  <= '0;
            o_imm <= '0;
            o_len <= '0;
            o_pc  <= '0;
        end else if (take) begin
            case (state)
                ST_FETCH1: begin
                    o_ir  <= i_dat;
                    o_imm <= '0;
                    o_len <= 2'd1;
                    o_pc  <= active_pc;
                end
                ST_FETCH2: begin
                    o_imm[15:0] <= i_dat;
                    o_len       <= 2'd2;
                end
                ST_FETCH3: begin
                    o_imm[31:16] <= i_dat;
                    o_len        <= 2'd3;
                end
                default: ;
            endcase
        end
    end

    // Banked PCs: redirect writes the selected bank, consumed acks step it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_sup <= PC_RST;
            pc_usr <= PC_RST;
        end else if (i_redirect) begin
            if (i_ub) pc_usr <= i_redirect_pc;
            else      pc_sup <= i_redirect_pc;
`ifdef DCPU_FETCH_IRQ_EN
        end else if (state == ST_IRQ) begin
            pc_sup <= PC_IRQ;
`endif
        end else if (take) begin
            if (i_ub) pc_usr <= pc_usr + PC_INC;
            else      pc_sup <= pc_sup + PC_INC;
        end
    end

endmodule

// File: tb/tb_dcpu_fetch.sv
// Directed testbench for dcpu_fetch (PC_STEP=2, byte-addressed).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dcpu_fetch;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        o_cyc;
    logic [1:0]  o_stb;
    logic        o_we;
    logic [31:0] o_addr;
    logic        i_ack;
    logic [15:0] i_dat;
    logic        i_ub;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_ir;
    logic [31:0] o_imm;
    logic [1:0]  o_len;
    logic [31:0] o_pc;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_int;
    logic        o_irq_taken;

    int checks = 0;
    int errors = 0;

    dcpu_fetch #(
        .ADDR_W    (32),
        .PC_STEP   (2),
        .RESET_PC  (32'h0),
        .IRQ_VECTOR(32'h10)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .o_cyc        (o_cyc),
        .o_stb        (o_stb),
        .o_we         (o_we),
        .o_addr       (o_addr),
        .i_ack        (i_ack),
        .i_dat        (i_dat),
        .i_ub         (i_ub),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_ir         (o_ir),
        .o_imm        (o_imm),
        .o_len        (o_len),
        .o_pc         (o_pc),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .i_int        (i_int),
        .o_irq_taken  (o_irq_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Serve one bus word after 'waits' wait states, checking the fetch address.
    task automatic bus_word(input logic [15:0] data, input int waits, input logic [31:0] addr);
        for (int w = 0; w < waits; w++) begin
            check("wait_cyc", o_cyc, 1);
            check("wait_valid", o_valid, 0);
            check("wait_addr", o_addr, addr);
            step();
        end
        check("cyc", o_cyc, 1);
        check("stb", o_stb, 2'b11);
        check("valid_low", o_valid, 0);
        check("addr", o_addr, addr);
        i_ack = 1'b1;
        i_dat = data;
        step();
        i_ack = 1'b0;
        i_dat = 16'h0;
    endtask

    task automatic expect_hold(input logic [15:0] ir, input logic [31:0] imm,
                               input logic [1:0] len, input logic [31:0] pc);
        check("hold_valid", o_valid, 1);
        check("hold_cyc", o_cyc, 0);
        check("hold_stb", o_stb, 2'b00);
        check("ir", o_ir, ir);
        check("imm", o_imm, imm);
        check("len", o_len, len);
        check("pc", o_pc, pc);
    endtask

    // Accept the held instruction; the next fetch starts one cycle later.
    task automatic accept(input logic [31:0] next_addr);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check("acc_valid", o_valid, 0);
        check("acc_cyc", o_cyc, 1);
        check("acc_addr", o_addr, next_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset       = 1'b1;
        i_ack         = 1'b0;
        i_dat         = 16'h0;
        i_ub          = 1'b0;
        i_ready       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_int         = 1'b0;

        // Reset held for two cycles.
        step();
        step();
        check("rst_cyc", o_cyc, 0);
        check("rst_valid", o_valid, 0);
        check("rst_stb", o_stb, 2'b00);
        check("rst_we", o_we, 0);
        check("rst_ir", o_ir, 0);
        check("rst_len", o_len, 0);
        check("rst_irq", o_irq_taken, 0);
        i_reset = 1'b0;
        step();  // RESET -> FETCH1

        // One-word instruction at address 0.
        bus_word(16'h1234, 0, 32'h0);
        expect_hold(16'h1234, 32'h0, 2'd1, 32'h0);
        accept(32'h2);

        // 0xE800: bits[15:13]=111 but bits[12:11]=01, so two words.
        bus_word(16'hE800, 0, 32'h2);
        bus_word(16'hBEEF, 0, 32'h4);
        expect_hold(16'hE800, 32'h0000_BEEF, 2'd2, 32'h2);
        // Backpressure: five cycles without ready, everything stable.
        for (int k = 0; k < 5; k++) begin
            step();
            expect_hold(16'hE800, 32'h0000_BEEF, 2'd2, 32'h2);
        end
        accept(32'h6);

        // 0xF800: bits[12:11]=11, so three words; zero-wait gives valid after 3 cycles.
        bus_word(16'hF800, 0, 32'h6);
        bus_word(16'hBEEF, 0, 32'h8);
        bus_word(16'hCAFE, 0, 32'hA);
        expect_hold(16'hF800, 32'hCAFE_BEEF, 2'd3, 32'h6);
        accept(32'hC);

        // Two wait states per word on a two-word instruction.
        bus_word(16'hE001, 2, 32'hC);
        bus_word(16'h1234, 2, 32'hE);
        expect_hold(16'hE001, 32'h0000_1234, 2'd2, 32'hC);
        accept(32'h10);

        // Redirect coincident with the FETCH2 ack: word dropped, no PC step.
        bus_word(16'hE000, 0, 32'h10);
        i_ack         = 1'b1;
        i_dat         = 16'h5555;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        step();
        i_ack      = 1'b0;
        i_redirect = 1'b0;
        check("redir_valid", o_valid, 0);
        check("redir_imm", o_imm, 32'h0);
        check("redir_cyc", o_cyc, 1);
        check("redir_addr", o_addr, 32'h100);
        bus_word(16'h0042, 0, 32'h100);
        expect_hold(16'h0042, 32'h0, 2'd1, 32'h100);

        // Redirect while holding drops o_valid.
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        step();
        i_redirect = 1'b0;
        check("hredir_valid", o_valid, 0);
        check("hredir_addr", o_addr, 32'h200);
        bus_word(16'h0007, 0, 32'h200);
        expect_hold(16'h0007, 32'h0, 2'd1, 32'h200);

        // Switch to the user bank at the accept cycle; user PC is still at reset value.
        i_ub = 1'b1;
        accept(32'h0);
        bus_word(16'h0001, 0, 32'h0);
        expect_hold(16'h0001, 32'h0, 2'd1, 32'h0);

        // Interrupt request at the accept cycle while in user mode.
        i_int   = 1'b1;
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
`ifdef DCPU_FETCH_IRQ_EN
        check("irq_pulse", o_irq_taken, 1);
        check("irq_cyc", o_cyc, 0);
        check("irq_valid", o_valid, 0);
        i_int = 1'b0;
        i_ub  = 1'b0;
        step();
        check("irq_pulse_end", o_irq_taken, 0);
        check("irq_vec_addr", o_addr, 32'h10);
        bus_word(16'h0002, 0, 32'h10);
        expect_hold(16'h0002, 32'h0, 2'd1, 32'h10);
        i_ub = 1'b1;
        accept(32'h2);  // user PC kept its value across the interrupt
`else
        check("noirq_pulse", o_irq_taken, 0);
        check("noirq_cyc", o_cyc, 1);
        check("noirq_addr", o_addr, 32'h2);
        i_int = 1'b0;
        step();
        check("noirq_pulse2", o_irq_taken, 0);
        check("noirq_addr2", o_addr, 32'h2);
`endif

        // Reset in the middle of a two-word fetch.
        bus_word(16'hE000, 0, 32'h2);
        i_reset = 1'b1;
        i_ub    = 1'b0;
        step();
        check("mrst_cyc", o_cyc, 0);
        check("mrst_valid", o_valid, 0);
        check("mrst_ir", o_ir, 0);
        check("mrst_len", o_len, 0);
        check("mrst_pc", o_pc, 0);
        step();
        i_reset = 1'b0;
        step();
        check("post_rst_cyc", o_cyc, 1);
        check("post_rst_addr", o_addr, 32'h0);
        // User bank was also reset.
        bus_word(16'h0003, 0, 32'h0);
        i_ub = 1'b1;
        accept(32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
